// File: rtl/mips_mem_pkg.sv
// Shared memory-side constants: MIPS load/store opcodes and the legal store
// byte-enable masks, used by the store-side BE generator and the MEM responder.
package mips_mem_pkg;

    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LHU = 6'd37;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_H0   = 4'b0011;
    localparam logic [3:0] BE_H1   = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } ld_res_t;

    // True when be is one of the legal masks and sits at the byte offset it implies.
    function automatic logic be_aligned(input logic [3:0] be, input logic [1:0] off);
        case (be)
            BE_B0, BE_H0, BE_W: be_aligned = (off == 2'd0);
            BE_B1:              be_aligned = (off == 2'd1);
            BE_B2, BE_H1:       be_aligned = (off == 2'd2);
            BE_B3:              be_aligned = (off == 2'd3);
            default:            be_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load field select and sign/zero extension; flags misaligned or unknown loads.
// Faulting loads return zero data.
module load_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [5:0]  ld_op_i,
    input  logic [1:0]  off_i,
    output ld_res_t     res_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word_i[8*off_i +: 8];
        half_sel   = off_i[1] ? word_i[31:16] : word_i[15:0];
        res_o.data  = '0;
        res_o.fault = 1'b0;
        case (ld_op_i)
            OP_LW: begin
                if (off_i != 2'd0) res_o.fault = 1'b1;
                else               res_o.data  = word_i;
            end
            OP_LB:  res_o.data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: res_o.data = {24'd0, byte_sel};
            OP_LH, OP_LHU: begin
                if (off_i[0])
                    res_o.fault = 1'b1;
                else if (ld_op_i == OP_LH)
                    res_o.data = {{16{half_sel[15]}}, half_sel};
                else
                    res_o.data = {16'd0, half_sel};
            end
            default: res_o.fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_be_responder.sv
// MEM-stage data memory: byte-enabled stores, registered loads with extension,
// and a one-cycle access-fault pulse for the previous request.
module dm_be_responder
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic [5:0]  ld_op,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       rel;
    logic              in_rng;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        off;
    logic              st_req, ld_req, st_ok;

    logic [31:0] rword_q, rword_d;
    logic [5:0]  ld_op_q, ld_op_d;
    logic [1:0]  off_q, off_d;
    logic        ld_pend_q, ld_pend_d;
    logic        rng_q, rng_d;
    logic        err_q, err_d;
    ld_res_t     ext;

    assign rel    = addr - BASE;
    assign in_rng = (addr >= BASE) && (rel[31:ADDR_W+2] == '0);
    assign widx   = rel[ADDR_W+1:2];
    assign off    = rel[1:0];
    assign st_req = we & ~re;
    assign ld_req = re & ~we;
    assign st_ok  = st_req && (be != BE_NONE) && in_rng && be_aligned(be, off);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (st_ok) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mem_q[widx][8*l +: 8] <= wdata[8*l +: 8];
        end
    end

    // The read word is captured raw; extension and load faults are resolved
    // on the captured copy, so rdata holds while no new load arrives.
    always_comb begin
        rword_d   = rword_q;
        ld_op_d   = ld_op_q;
        off_d     = off_q;
        ld_pend_d = ld_req;
        rng_d     = ld_req & ~in_rng;
        err_d     = (we & re)
                  | (st_req && (be != BE_NONE) && !(in_rng && be_aligned(be, off)))
                  | (ld_req & ~in_rng);
        if (ld_req) begin
            rword_d = in_rng ? mem_q[widx] : '0;
            ld_op_d = ld_op;
            off_d   = off;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rword_q   <= '0;
            ld_op_q   <= '0;
            off_q     <= '0;
            ld_pend_q <= 1'b0;
            rng_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rword_q   <= rword_d;
            ld_op_q   <= ld_op_d;
            off_q     <= off_d;
            ld_pend_q <= ld_pend_d;
            rng_q     <= rng_d;
            err_q     <= err_d;
        end
    end

    load_ext u_ext (
        .word_i  (rword_q),
        .ld_op_i (ld_op_q),
        .off_i   (off_q),
        .res_o   (ext)
    );

    assign rdata  = ext.data;
    assign rvalid = ld_pend_q & ~rng_q & ~ext.fault;
    assign err    = err_q | (ld_pend_q & ext.fault);

endmodule

// File: tb/tb_dm_be_responder.sv
// Randomized bench for dm_be_responder against a behavioural word-memory model,
// plus directed scenarios pinned to hand-computed values.
module tb_dm_be_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        we, re;
    logic [3:0]  be;
    logic [5:0]  ld_op;
    logic [31:0] rdata;
    logic        rvalid, err;

    always #5 clk = ~clk;

    dm_be_responder #(.ADDR_W(10), .BASE(32'h0)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .be(be), .wdata(wdata),
        .re(re), .ld_op(ld_op), .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    logic [31:0] mdl_mem [1024];
    logic [31:0] exp_rd;
    logic        exp_v, exp_e;
    bit          chk_en = 0;
    int          n_chk = 0, n_fail = 0;

    bit          lit_on = 0, lit_rd_en;
    string       lit_name;
    logic [31:0] lit_rd;
    logic        lit_v, lit_e;

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk = n_chk + 1;
            if (rdata !== exp_rd || rvalid !== exp_v || err !== exp_e) begin
                n_fail = n_fail + 1;
                $display("FAIL model t=%0t addr=%h rdata=%h want %h rvalid=%b want %b err=%b want %b",
                         $time, addr, rdata, exp_rd, rvalid, exp_v, err, exp_e);
            end
            if (lit_on) begin
                n_chk = n_chk + 1;
                if ((lit_rd_en && rdata !== lit_rd) || rvalid !== lit_v || err !== lit_e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s rdata=%h want %h rvalid=%b want %b err=%b want %b",
                             lit_name, rdata, lit_rd, rvalid, lit_v, err, lit_e);
                end
            end
        end
    end

    task automatic mdl_clear();
        for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;
        exp_rd = '0; exp_v = 1'b0; exp_e = 1'b0;
    endtask

    // Drive one request, advance one clock, and update the model's view.
    task automatic cyc(input bit w, input bit r, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd, input logic [5:0] op);
        logic [31:0] nrd, val, res;
        logic        nv, ne, do_wr, flt;
        int unsigned o, idx, lowbit, part;
        bit          inr;
        we = w; re = r; addr = a; be = b; wdata = wd; ld_op = op;
        inr = (a < 32'd4096);
        idx = a / 4; o = a % 4;
        nrd = exp_rd; nv = 0; ne = 0; do_wr = 0;
        if (w && r) ne = 1;
        else if (w && b != 0) begin
            lowbit = 0;
            while (!b[lowbit]) lowbit++;
            if (!inr || !(b inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15}) || o != lowbit)
                ne = 1;
            else do_wr = 1;
        end else if (r) begin
            flt = 0; res = 0;
            val = inr ? mdl_mem[idx] : 32'd0;
            if (!inr) flt = 1;
            else case (op)
                6'd35: if (o != 0) flt = 1; else res = val;
                6'd32, 6'd36: begin
                    part = (val >> (8 * o)) & 32'hFF;
                    res = (op == 6'd32 && part >= 128) ? part + 32'hFFFF_FF00 : part;
                end
                6'd33, 6'd37: begin
                    if (o % 2 != 0) flt = 1;
                    else begin
                        part = (val >> (8 * o)) & 32'hFFFF;
                        res = (op == 6'd33 && part >= 32768) ? part + 32'hFFFF_0000 : part;
                    end
                end
                default: flt = 1;
            endcase
            if (flt) begin ne = 1; nrd = 0; end
            else begin nv = 1; nrd = res; end
        end
        @(posedge clk);
        #1;
        if (do_wr)
            for (int l = 0; l < 4; l++)
                if (b[l]) mdl_mem[idx][8*l +: 8] = wd[8*l +: 8];
        exp_rd = nrd; exp_v = nv; exp_e = ne;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 6'd0);
    endtask

    task automatic lit(input string nm, input logic [31:0] rd, input bit rd_en,
                       input logic v, input logic e);
        lit_name = nm; lit_rd = rd; lit_rd_en = rd_en; lit_v = v; lit_e = e;
        lit_on = 1;
        @(negedge clk);
        #1 lit_on = 0;
    endtask

    initial begin
        reset = 1'b1;
        we = 0; re = 0; addr = 0; be = 0; wdata = 0; ld_op = 0;
        mdl_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1;
        lit("reset_state", 32'h0, 1, 0, 0);

        // Reset in the middle of a load request
        cyc(1, 0, 32'h10, 4'hF, 32'h0BAD_F00D, 6'd0);
        we = 0; re = 1; addr = 32'h10; ld_op = 6'd35;
        #1 reset = 1'b1;
        mdl_clear();
        #1 re = 0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        lit("reset_midload", 32'h0, 1, 0, 0);
        cyc(0, 1, 32'h10, 4'h0, 32'h0, 6'd35);
        lit("mem4_cleared", 32'h0, 1, 1, 0);

        // Byte store merge
        cyc(1, 0, 32'h20, 4'hF, 32'h1122_3344, 6'd43);
        cyc(1, 0, 32'h22, 4'h4, 32'h00AA_0000, 6'd40);
        cyc(0, 1, 32'h20, 4'h0, 32'h0, 6'd35);
        lit("byte_merge", 32'h11AA_3344, 1, 1, 0);

        // Extension
        cyc(1, 0, 32'h30, 4'hF, 32'h80FF_7F01, 6'd43);
        cyc(0, 1, 32'h33, 4'h0, 32'h0, 6'd32); lit("lb_0x33",  32'hFFFF_FF80, 1, 1, 0);
        cyc(0, 1, 32'h33, 4'h0, 32'h0, 6'd36); lit("lbu_0x33", 32'h0000_0080, 1, 1, 0);
        cyc(0, 1, 32'h30, 4'h0, 32'h0, 6'd33); lit("lh_0x30",  32'h0000_7F01, 1, 1, 0);
        cyc(0, 1, 32'h32, 4'h0, 32'h0, 6'd33); lit("lh_0x32",  32'hFFFF_80FF, 1, 1, 0);
        cyc(0, 1, 32'h32, 4'h0, 32'h0, 6'd37); lit("lhu_0x32", 32'h0000_80FF, 1, 1, 0);

        // Faults
        cyc(0, 1, 32'h31, 4'h0, 32'h0, 6'd35); lit("lw_misaligned", 32'h0, 1, 0, 1);
        idle();                                 lit("idle_after_err", 32'h0, 1, 0, 0);
        cyc(1, 0, 32'h32, 4'h3, 32'h5555_6666, 6'd41); lit("sh_misaligned", 32'h0, 0, 0, 1);
        cyc(1, 0, 32'h30, 4'h5, 32'h1234_5678, 6'd43); lit("be_0101", 32'h0, 0, 0, 1);
        cyc(0, 1, 32'h30, 4'h0, 32'h0, 6'd35); lit("mem_unchanged", 32'h80FF_7F01, 1, 1, 0);
        cyc(0, 1, 32'h1000, 4'h0, 32'h0, 6'd35); lit("out_of_range", 32'h0, 1, 0, 1);
        cyc(0, 1, 32'h30, 4'h0, 32'h0, 6'd7);  lit("unknown_op", 32'h0, 1, 0, 1);
        cyc(1, 0, 32'h34, 4'h0, 32'hFFFF_FFFF, 6'd43); lit("be_none", 32'h0, 1, 0, 0);

        // Back-to-back store/load/load
        cyc(1, 0, 32'h40, 4'hF, 32'hDEAD_BEEF, 6'd43);
        cyc(0, 1, 32'h40, 4'h0, 32'h0, 6'd35); lit("b2b_first", 32'hDEAD_BEEF, 1, 1, 0);
        cyc(0, 1, 32'h44, 4'h0, 32'h0, 6'd35); lit("b2b_second", 32'h0, 1, 1, 0);

        // Store and load in the same cycle
        cyc(1, 1, 32'h50, 4'hF, 32'h1234_5678, 6'd35); lit("conflict", 32'h0, 0, 0, 1);
        cyc(0, 1, 32'h50, 4'h0, 32'h0, 6'd35); lit("conflict_nowrite", 32'h0, 1, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, wd;
            logic [3:0]  b;
            logic [5:0]  op;
            bit          w, r;
            int unsigned sel;
            logic [3:0]  masks [7];
            masks = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
            sel = $urandom_range(0, 99);
            if (sel < 80)      a = $urandom_range(0, 127);
            else if (sel < 90) a = $urandom_range(4096 - 16, 4096 + 15);
            else               a = $urandom;
            sel = $urandom_range(0, 99);
            w = (sel < 40) || (sel >= 95);
            r = (sel >= 40 && sel < 85) || (sel >= 95);
            if ($urandom_range(0, 3) != 0) begin
                b = masks[$urandom_range(0, 6)];
                if ($urandom_range(0, 3) != 0)
                    case (b)
                        4'h2: a[1:0] = 2'd1;
                        4'h4, 4'hC: a[1:0] = 2'd2;
                        4'h8: a[1:0] = 2'd3;
                        default: a[1:0] = 2'd0;
                    endcase
            end else b = 4'($urandom);
            wd = $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0: op = 6'd35; 1: op = 6'd32; 2: op = 6'd36;
                3: op = 6'd33; 4: op = 6'd37; default: op = 6'($urandom);
            endcase
            cyc(w, r, a, b, wd, op);
        end

        idle();
        @(negedge clk);
        #1 chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_be_responder.md
Name: dm_be_responder

Overview:
- Data-memory responder at the MEM stage: the consumer of the 4-bit store byte-enable mask and the source of load data.
- Stores: writes only the enabled byte lanes into a word-organised memory.
- Loads: performs a registered read, then the sign/zero extension for lb/lbu/lh/lhu/lw.
- The result is presented to the MEM/WB boundary one cycle after the request.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words.
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  32  byte address from the ALU result
- we  in  1  store request this cycle
- be  in  4  store byte-enable mask, lane i = bits [8i+7:8i]
- wdata  in  32  store data, already replicated into lanes by the store path
- re  in  1  load request this cycle
- ld_op  in  6  load opcode: 35 lw, 32 lb, 36 lbu, 33 lh, 37 lhu
- rdata  out  32  extended load result, registered
- rvalid  out  1  rdata valid, one-cycle pulse
- err  out  1  access fault for the previous-cycle request, registered pulse

Behaviour:
- Reset (async, active-high):
  - rdata=0, rvalid=0, err=0.
  - Every memory word = 0.
  - Internal ld_op_q and off_q = 0.
  - An in-flight load is discarded; rvalid does not pulse after reset deasserts.
- Word index = (addr-BASE)[ADDR_W+1:2]; off = addr[1:0].
- Range fault: addr < BASE or addr-BASE >= 4*2**ADDR_W.
- Store (we=1, re=0):
  - Legal be masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Alignment check: a single lane requires off = lane index; 0011 requires off=0; 1100 requires off=2; 1111 requires off=0.
  - Legal, aligned, in range: at the clock edge, write only the enabled lanes; other lanes keep their value.
  - be=0000: no write, no err.
  - Illegal mask, misaligned, or out of range: no write; err=1 next cycle.
- Load (re=1, we=0):
  - Capture mem[word], ld_op and off at the edge.
  - Next cycle: rvalid=1, rdata = extension of the selected field.
    - lw: whole word.
    - lb / lbu: byte at off, sign- / zero-extended.
    - lh / lhu: half at off[1], sign- / zero-extended.
  - Latency is exactly 1 cycle; back-to-back loads give back-to-back rvalid.
- Load faults, all giving rdata=0, rvalid=0, err=1 next cycle:
  - lw with off≠0.
  - lh/lhu with off[0]=1.
  - Unknown ld_op.
  - Out of range.
- Store then load to the same word on consecutive cycles: the load sees the new data (write commits at edge N, read at edge N+1).
- we=1 and re=1 in the same cycle is a protocol violation: no write, no read, err=1 next cycle.
- Idle (we=0, re=0): rvalid=0, err=0; rdata holds its last value.

Decomposition:
- Shared package mips_mem_pkg:
  - Opcode constants OP_LW=35, OP_LB=32, OP_LBU=36, OP_LH=33, OP_LHU=37, OP_SW=43, OP_SB=40, OP_SH=41.
  - Legal byte-enable mask constants, shared with the store-side byte-enable generator.
- One natural sub-module: load_ext.
  - Combinational: (word, ld_op, off) → (data, fault).
  - Also reused by the exception/debug path.

Test Plan:
- Reset mid-load: re=1 addr=0x10 lw, reset pulses before the edge → rvalid=0 and rdata=0 after release; mem[4] reads back 0.
- Byte store merge: sw 0x11223344 to 0x20; then sb be=0100 wdata=0x00AA0000 at 0x22; then lw 0x20 → rdata=0x11AA3344, rvalid=1 one cycle after re.
- Extension: mem word at 0x30 = 0x80FF7F01:
  - lb 0x33 → 0xFFFFFF80; lbu 0x33 → 0x00000080.
  - lh 0x30 → 0x00007F01; lh 0x32 → 0xFFFF80FF; lhu 0x32 → 0x000080FF.
- Faults:
  - lw 0x31 → err=1, rvalid=0.
  - sh be=0011 at 0x32 → err=1, memory unchanged.
  - be=0101 → err=1, no write.
  - addr=0x1000 with ADDR_W=10 → err=1.
- Back-to-back: sw 0xDEADBEEF @0x40 at cycle N, lw @0x40 at N+1, lw @0x44 at N+2 → rvalid high N+2 and N+3; rdata=0xDEADBEEF then 0.
- Conflict: we=1 and re=1 same cycle → err=1 next cycle, no write, rvalid=0.
